// File: rtl/vec_mul_sequencer_if.sv
// Bundle of signals between the operand feeder / result consumer / adder tree
// and the vec_mul_sequencer.
//
// Handshake semantics (both the in_* and out_* channels): a transfer happens on
// a rising clk edge where valid and ready are both 1. The sequencer's ready
// outputs depend only on its own state, never on the partner's valid. Once the
// sequencer raises out_valid, it holds out_valid, out_data and out_row stable
// until the edge where out_ready is seen high.
interface vec_mul_sequencer_if #(
    parameter int DATA_BW        = 8,
    parameter int PARTIAL_SUM_BW = 20,
    parameter int MATRIX_SIZE    = 8,
    parameter int ACC_BW         = 32,
    parameter int CNT_BW         = 8
);
    logic [CNT_BW-1:0]              cfg_num_chunks;
    logic [CNT_BW-1:0]              cfg_num_rows;
    logic                           start;
    logic                           busy;
    logic                           done;
    logic                           in_valid;
    logic                           in_ready;
    logic [DATA_BW*MATRIX_SIZE-1:0] in_vec_flat;
    logic [DATA_BW*MATRIX_SIZE-1:0] in_wgt_flat;
    logic [DATA_BW*MATRIX_SIZE-1:0] mul_a_flat;
    logic [DATA_BW*MATRIX_SIZE-1:0] mul_b_flat;
    logic                           mul_en;
    logic [PARTIAL_SUM_BW-1:0]      tree_sum;
    logic                           out_valid;
    logic                           out_ready;
    logic [ACC_BW-1:0]              out_data;
    logic [CNT_BW-1:0]              out_row;

    // Sequencer side
    modport slave (
        input  cfg_num_chunks, cfg_num_rows, start, in_valid, in_vec_flat,
               in_wgt_flat, tree_sum, out_ready,
        output busy, done, in_ready, mul_a_flat, mul_b_flat, mul_en,
               out_valid, out_data, out_row
    );

    // Feeder / consumer / adder-tree side
    modport master (
        output cfg_num_chunks, cfg_num_rows, start, in_valid, in_vec_flat,
               in_wgt_flat, tree_sum, out_ready,
        input  busy, done, in_ready, mul_a_flat, mul_b_flat, mul_en,
               out_valid, out_data, out_row
    );
endinterface

// File: rtl/vec_mul_sequencer.sv
// Sequences operand chunks onto the vec_mul/adder_tree array and accumulates
// the per-chunk tree sums into one signed dot product per output row.
module vec_mul_sequencer #(
    parameter int DATA_BW        = 8,
    parameter int PARTIAL_SUM_BW = 20,
    parameter int MATRIX_SIZE    = 8,
    parameter int ACC_BW         = 32,
    parameter int CNT_BW         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    vec_mul_sequencer_if.slave    bus,
    output logic [1:0]            dbg_state
);
    localparam int VEC_BW = DATA_BW * MATRIX_SIZE;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]        state;
    logic [CNT_BW-1:0] num_chunks_q;
    logic [CNT_BW-1:0] num_rows_q;
    logic [CNT_BW-1:0] issued;
    logic [CNT_BW-1:0] row_cnt;
    logic [ACC_BW-1:0] acc;
    logic              first_q;     // mul_a/b currently hold chunk 0 of a row
    logic              done_q;
    logic              mul_en_q;
    logic [VEC_BW-1:0] mul_a_q;
    logic [VEC_BW-1:0] mul_b_q;
    logic              out_valid_q;
    logic [ACC_BW-1:0] out_data_q;
    logic [CNT_BW-1:0] out_row_q;

    logic              start_ok;
    logic              xfer;
    logic              last_chunk;
    logic              last_row;
    logic              out_hs;
    logic [ACC_BW-1:0] tree_sext;

    assign start_ok   = bus.start && (bus.cfg_num_chunks != '0) && (bus.cfg_num_rows != '0);
    assign bus.in_ready = (state == S_RUN) && (issued < num_chunks_q);
    assign xfer       = bus.in_valid && bus.in_ready;
    assign last_chunk = (issued == num_chunks_q - CNT_BW'(1));
    assign last_row   = (row_cnt == num_rows_q - CNT_BW'(1));
    assign out_hs     = out_valid_q && bus.out_ready;
    assign tree_sext  = ACC_BW'($signed(bus.tree_sum));

    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = done_q;
    assign bus.mul_en     = mul_en_q;
    assign bus.mul_a_flat = mul_a_q;
    assign bus.mul_b_flat = mul_b_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_row    = out_row_q;
    assign dbg_state      = state;

    // Control FSM: job config latch, chunk/row counters and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            num_chunks_q <= '0;
            num_rows_q   <= '0;
            issued       <= '0;
            row_cnt      <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        num_chunks_q <= bus.cfg_num_chunks;
                        num_rows_q   <= bus.cfg_num_rows;
                        issued       <= '0;
                        row_cnt      <= '0;
                        state        <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        issued <= issued + CNT_BW'(1);
                        if (last_chunk) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (out_hs) begin
                        if (last_row) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            row_cnt <= row_cnt + CNT_BW'(1);
                            issued  <= '0;
                            state   <= S_RUN;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Operand registers: capture an accepted chunk, otherwise hold with mul_en low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            mul_en_q <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            mul_en_q <= xfer;
            if (xfer) begin
                mul_a_q <= bus.in_vec_flat;
                mul_b_q <= bus.in_wgt_flat;
                first_q <= (issued == '0);
            end
        end
    end

    // Accumulator: the first chunk of a row restarts the sum, so no explicit clear is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (mul_en_q) begin
            acc <= (first_q ? '0 : acc) + tree_sext;
        end
    end

    // Result register: loaded once on the first OUT cycle, then held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
        end else if ((state == S_OUT) && !out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc;
            out_row_q   <= row_cnt;
        end else if (out_hs) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Testbench for vec_mul_sequencer: drives jobs through the interface, models
// the adder tree, and compares row results against dot products computed
// directly from the stimulus.
module tb_vec_mul_sequencer;
    localparam int DW = 8;
    localparam int PS = 20;
    localparam int MS = 8;
    localparam int AW = 32;
    localparam int CW = 8;
    localparam int VW = DW * MS;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    vec_mul_sequencer_if #(.DATA_BW(DW), .PARTIAL_SUM_BW(PS), .MATRIX_SIZE(MS),
                           .ACC_BW(AW), .CNT_BW(CW)) bus ();

    vec_mul_sequencer #(.DATA_BW(DW), .PARTIAL_SUM_BW(PS), .MATRIX_SIZE(MS),
                        .ACC_BW(AW), .CNT_BW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- adder tree model ----------------
    function automatic logic [PS-1:0] tree_fn(input logic [VW-1:0] a, input logic [VW-1:0] b);
        int s;
        s = 0;
        for (int i = 0; i < MS; i++) s += int'($signed(a[i*DW +: DW])) * int'($signed(b[i*DW +: DW]));
        return s[PS-1:0];
    endfunction
    assign bus.tree_sum = tree_fn(bus.mul_a_flat, bus.mul_b_flat);

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [VW-1:0] stim_vec[$];
    logic [VW-1:0] stim_wgt[$];
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] got_data[$];
    logic [CW-1:0] got_row[$];
    int lat_q[$];
    int in_ready_cycles, mul_en_viol, hold_viol, inready_in_out, done_cnt, hold_seen;
    bit timed_out;

    function automatic logic [VW-1:0] splat(input logic [DW-1:0] e);
        logic [VW-1:0] v;
        for (int i = 0; i < MS; i++) v[i*DW +: DW] = e;
        return v;
    endfunction

    task automatic fill_const(input int n, input logic [DW-1:0] ve, input logic [DW-1:0] we);
        stim_vec.delete(); stim_wgt.delete();
        for (int i = 0; i < n; i++) begin
            stim_vec.push_back(splat(ve));
            stim_wgt.push_back(splat(we));
        end
    endtask

    task automatic fill_random(input int n);
        logic [VW-1:0] v, w;
        stim_vec.delete(); stim_wgt.delete();
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < MS; k++) begin
                v[k*DW +: DW] = DW'($urandom);
                w[k*DW +: DW] = DW'($urandom);
            end
            stim_vec.push_back(v);
            stim_wgt.push_back(w);
        end
    endtask

    // Reference: each row result is the full-length signed dot product of its chunks.
    task automatic build_expected(input int chunks, input int rows);
        int s;
        logic [VW-1:0] v, w;
        exp_q.delete();
        for (int r = 0; r < rows; r++) begin
            s = 0;
            for (int c = 0; c < chunks; c++) begin
                v = stim_vec[r*chunks + c];
                w = stim_wgt[r*chunks + c];
                for (int i = 0; i < MS; i++) s += int'($signed(v[i*DW +: DW])) * int'($signed(w[i*DW +: DW]));
            end
            exp_q.push_back(AW'(s));
        end
    endtask

    // ---------------- driver ----------------
    // gap_mode: 0 valid always, 1 valid on even cycles, 2 random valid.
    // bp_mode : 0 ready always, 1 random ready, 2 ready low for the first 5 valid cycles.
    task automatic run_job(input int chunks, input int rows, input int gap_mode,
                           input int bp_mode, input bit restart);
        int idx, cyc, total, lx, hold_left;
        bit fin, prev_xfer, prev_wait, prev_ov, xfer, hs, v;
        logic [AW-1:0] prev_data;
        logic [CW-1:0] prev_row;
        idx = 0; cyc = 0; total = chunks * rows; lx = 0; hold_left = 5;
        fin = 0; prev_xfer = 0; prev_wait = 0; prev_ov = 0;
        prev_data = '0; prev_row = '0;
        got_data.delete(); got_row.delete(); lat_q.delete();
        in_ready_cycles = 0; mul_en_viol = 0; hold_viol = 0; inready_in_out = 0;
        done_cnt = 0; hold_seen = 0;
        bus.cfg_num_chunks = CW'(chunks);
        bus.cfg_num_rows   = CW'(rows);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (!fin && cyc < 2000) begin
            bus.start = restart && (cyc == 2);
            if (restart && cyc == 2) begin
                bus.cfg_num_chunks = CW'(5);
                bus.cfg_num_rows   = CW'(3);
            end
            case (gap_mode)
                0: v = 1'b1;
                1: v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            bus.in_valid = (idx < total) && v;
            if (idx < total) begin
                bus.in_vec_flat = stim_vec[idx];
                bus.in_wgt_flat = stim_wgt[idx];
            end
            case (bp_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.out_valid && hold_left > 0) begin
                        bus.out_ready = 1'b0;
                        hold_left--;
                        hold_seen++;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
            endcase
            if (bus.in_ready) in_ready_cycles++;
            if (bus.out_valid && bus.in_ready) inready_in_out++;
            if (bus.mul_en !== prev_xfer) mul_en_viol++;
            if (prev_wait && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_row !== prev_row))
                hold_viol++;
            if (bus.out_valid && !prev_ov) lat_q.push_back(cyc - lx);
            if (bus.done) begin done_cnt++; fin = 1; end
            xfer = bus.in_valid && bus.in_ready;
            hs   = bus.out_valid && bus.out_ready;
            if (xfer && (idx % chunks == chunks - 1)) lx = cyc;
            if (hs) begin
                got_data.push_back(bus.out_data);
                got_row.push_back(bus.out_row);
            end
            prev_xfer = xfer;
            prev_wait = bus.out_valid && !bus.out_ready;
            prev_ov   = bus.out_valid;
            prev_data = bus.out_data;
            prev_row  = bus.out_row;
            @(posedge clk); #1;
            cyc++;
            if (xfer) idx++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.start = 1'b0;
        timed_out = !fin;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: busy=%b done=%b in_ready=%b required 0 0 0", bus.busy, bus.done, bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_row !== '0) begin
            errors++; $display("FAIL reset_out: valid=%b data=%0h row=%0d required 0", bus.out_valid, bus.out_data, bus.out_row); end
        checks++; if (bus.mul_en !== 1'b0 || bus.mul_a_flat !== '0 || bus.mul_b_flat !== '0) begin
            errors++; $display("FAIL reset_mul: en=%b a=%0h b=%0h required 0", bus.mul_en, bus.mul_a_flat, bus.mul_b_flat); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        fill_const(1, 8'd1, 8'd2);
        build_expected(1, 1);
        run_job(1, 1, 0, 0, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL t1_timeout: job did not finish"); end
        checks++; if (got_data.size() != 1) begin errors++; $display("FAIL t1_count: got %0d results required 1", got_data.size()); end
        checks++; if (got_data.size() > 0 && got_data[0] !== 32'd16) begin
            errors++; $display("FAIL t1_data: got %0d required 16", $signed(got_data[0])); end
        checks++; if (got_row.size() > 0 && got_row[0] !== '0) begin errors++; $display("FAIL t1_row: got %0d required 0", got_row[0]); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL t1_done: got %0d pulses required 1", done_cnt); end
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL t1_done_pulse: done=%b busy=%b a cycle later, required 0 0", bus.done, bus.busy); end
        checks++; if (lat_q.size() != 1 || lat_q[0] != 3) begin
            errors++; $display("FAIL t1_latency: got %0d required 3", lat_q.size() > 0 ? lat_q[0] : -1); end
    endtask

    task automatic test_multi_row();
        fill_const(8, 8'd1, 8'd1);
        build_expected(4, 2);
        run_job(4, 2, 0, 0, 0);
        checks++; if (timed_out || got_data.size() != 2) begin
            errors++; $display("FAIL t2_count: got %0d results required 2 (timeout=%0b)", got_data.size(), timed_out); end
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== exp_q[i] || got_row[i] !== CW'(i)) begin
                errors++; $display("FAIL t2_row%0d: got data=%0d row=%0d required data=%0d row=%0d",
                                   i, $signed(got_data[i]), got_row[i], $signed(exp_q[i]), i); end
        end
        checks++; if (in_ready_cycles != 8) begin errors++; $display("FAIL t2_in_ready: got %0d cycles required 8", in_ready_cycles); end
        checks++; if (lat_q.size() != 2 || lat_q[0] != 3 || lat_q[1] != 3) begin
            errors++; $display("FAIL t2_latency: got %0d rises, first %0d, required 2 rises of 3", lat_q.size(), lat_q.size() > 0 ? lat_q[0] : -1); end
    endtask

    task automatic test_backpressure();
        fill_random(2);
        build_expected(2, 1);
        run_job(2, 1, 0, 2, 0);
        checks++; if (timed_out || got_data.size() != 1 || got_data[0] !== exp_q[0]) begin
            errors++; $display("FAIL t3_data: got %0d results first %0h required %0h", got_data.size(),
                               got_data.size() > 0 ? got_data[0] : '0, exp_q[0]); end
        checks++; if (hold_seen != 5) begin errors++; $display("FAIL t3_hold_len: held %0d cycles required 5", hold_seen); end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL t3_stable: %0d changes while stalled required 0", hold_viol); end
        checks++; if (inready_in_out != 0) begin errors++; $display("FAIL t3_in_ready: %0d cycles high during output required 0", inready_in_out); end
    endtask

    task automatic test_gapped();
        fill_const(3, 8'hFF, 8'd5);
        build_expected(3, 1);
        run_job(3, 1, 1, 0, 0);
        checks++; if (timed_out || got_data.size() != 1 || got_data[0] !== 32'hFFFF_FF88) begin
            errors++; $display("FAIL t4_data: got %0d results first %0d required -120", got_data.size(),
                               got_data.size() > 0 ? $signed(got_data[0]) : 0); end
        checks++; if (mul_en_viol != 0) begin errors++; $display("FAIL t4_mul_en: %0d cycles off the transfer pattern required 0", mul_en_viol); end
    endtask

    task automatic test_ignored_start();
        bus.cfg_num_chunks = '0; bus.cfg_num_rows = CW'(1); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.cfg_num_chunks = CW'(1); bus.cfg_num_rows = '0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t5_zero_cfg: busy=%b required 0", bus.busy); end
            @(posedge clk); #1;
        end
        fill_random(2);
        build_expected(2, 1);
        run_job(2, 1, 0, 0, 1);
        checks++; if (timed_out || got_data.size() != 1 || got_data[0] !== exp_q[0]) begin
            errors++; $display("FAIL t5_restart: got %0d results first %0h required one of %0h", got_data.size(),
                               got_data.size() > 0 ? got_data[0] : '0, exp_q[0]); end
        checks++; if (in_ready_cycles != 2) begin errors++; $display("FAIL t5_cfg_kept: in_ready %0d cycles required 2", in_ready_cycles); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t5_idle_after: busy=%b required 0", bus.busy); end
    endtask

    task automatic test_reset_mid_job();
        bus.cfg_num_chunks = CW'(4); bus.cfg_num_rows = CW'(1); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_vec_flat = splat(8'd3); bus.in_wgt_flat = splat(8'd7);
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.mul_en !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL t6_async_ctrl: busy=%b in_ready=%b mul_en=%b done=%b required 0", bus.busy, bus.in_ready, bus.mul_en, bus.done); end
        checks++; if (bus.mul_a_flat !== '0 || bus.mul_b_flat !== '0 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            errors++; $display("FAIL t6_async_data: a=%0h b=%0h valid=%b data=%0h required 0", bus.mul_a_flat, bus.mul_b_flat, bus.out_valid, bus.out_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        fill_random(2);
        build_expected(2, 1);
        run_job(2, 1, 0, 0, 0);
        checks++; if (timed_out || got_data.size() != 1 || got_data[0] !== exp_q[0]) begin
            errors++; $display("FAIL t6_fresh_job: got %0d results first %0h required %0h", got_data.size(),
                               got_data.size() > 0 ? got_data[0] : '0, exp_q[0]); end
    endtask

    task automatic test_random();
        int ch, rw;
        for (int j = 0; j < 6; j++) begin
            ch = $urandom_range(1, 5);
            rw = $urandom_range(1, 3);
            fill_random(ch * rw);
            build_expected(ch, rw);
            run_job(ch, rw, 2, 1, 0);
            checks++; if (timed_out || got_data.size() != exp_q.size()) begin
                errors++; $display("FAIL rnd%0d_count: got %0d results required %0d (timeout=%0b)", j, got_data.size(), exp_q.size(), timed_out); end
            for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
                checks++; if (got_data[i] !== exp_q[i] || got_row[i] !== CW'(i)) begin
                    errors++; $display("FAIL rnd%0d_row%0d: got data=%0h row=%0d required data=%0h row=%0d",
                                       j, i, got_data[i], got_row[i], exp_q[i], i); end
            end
            checks++; if (mul_en_viol != 0 || hold_viol != 0 || inready_in_out != 0) begin
                errors++; $display("FAIL rnd%0d_protocol: mul_en=%0d hold=%0d in_ready_in_out=%0d required 0 0 0",
                                   j, mul_en_viol, hold_viol, inready_in_out); end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst = 1'b1;
        bus.cfg_num_chunks = '0; bus.cfg_num_rows = '0; bus.start = 1'b0;
        bus.in_valid = 1'b0; bus.in_vec_flat = '0; bus.in_wgt_flat = '0; bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_multi_row();
        test_backpressure();
        test_gapped();
        test_ignored_start();
        test_reset_mid_job();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
